// File: rtl/demux4_reg.sv
// demux4_reg: one-word registered demultiplexer. An input word is steered
// into one of four single-entry holding registers selected by sel; each
// channel then drains independently through its own valid/ready handshake.
// A 16-bit counter tallies accepted input words.
module demux4_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [15:0]      xfer_count
);

  logic [3:0]       full_q;
  logic [3:0]       full_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [15:0]      count_q;
  logic [15:0]      count_d;

  logic [3:0]       out_ready;
  logic [3:0]       drain;
  logic [3:0]       load;
  logic             accept;

  assign out_ready = {out_ready3, out_ready2, out_ready1, out_ready0};

  // Ready depends only on the addressed channel: empty, or emptying this edge.
  assign in_ready = ~full_q[sel] | out_ready[sel];
  assign accept   = in_valid & in_ready;

  // Per-channel next state: a load wins over a drain so drain+load keeps
  // the channel full with the new word and no bubble.
  always_comb begin
    full_d  = full_q;
    drain   = '0;
    load    = '0;
    count_d = count_q;
    for (int unsigned k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      drain[k]  = full_q[k] & out_ready[k];
      load[k]   = accept & (sel == 2'(k));
      if (load[k]) begin
        full_d[k] = 1'b1;
        data_d[k] = in_data;
      end else if (drain[k]) begin
        full_d[k] = 1'b0;
      end
    end
    if (accept) begin
      count_d = count_q + 16'd1;
    end
  end

  // State registers; reset empties every channel and zeroes data and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q  <= full_d;
      count_q <= count_d;
      for (int unsigned k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid0 = full_q[0];
  assign out_valid1 = full_q[1];
  assign out_valid2 = full_q[2];
  assign out_valid3 = full_q[3];
  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign out_data3  = data_q[3];
  assign xfer_count = count_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Testbench for demux4_reg: per-channel scoreboard queues hold accepted
// words until delivered; a vector table plus hand-written sequences.
module tb_demux4_reg;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   sel;
  logic         ov0, ov1, ov2, ov3;
  logic         ordy0, ordy1, ordy2, ordy3;
  logic [W-1:0] od0, od1, od2, od3;
  logic [15:0]  xfer_count;

  logic [3:0]   ov;
  logic [W-1:0] od [4];

  assign ov    = {ov3, ov2, ov1, ov0};
  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = od2;
  assign od[3] = od3;

  demux4_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sel        (sel),
    .out_valid0 (ov0),
    .out_valid1 (ov1),
    .out_valid2 (ov2),
    .out_valid3 (ov3),
    .out_ready0 (ordy0),
    .out_ready1 (ordy1),
    .out_ready2 (ordy2),
    .out_ready3 (ordy3),
    .out_data0  (od0),
    .out_data1  (od1),
    .out_data2  (od2),
    .out_data3  (od3),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: words pushed on acceptance, popped on delivery.
  logic [W-1:0] sbq [4][$];
  logic [15:0]  m_count;

  typedef struct {
    logic         iv;
    logic [1:0]   s;
    logic [W-1:0] d;
    logic [3:0]   ordy;
    logic         exp_rdy;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_ready(input logic [3:0] r);
    ordy0 = r[0];
    ordy1 = r[1];
    ordy2 = r[2];
    ordy3 = r[3];
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) sbq[k].delete();
    m_count = '0;
  endtask

  // Called just after a rising edge: drive, check at the falling edge,
  // then advance the scoreboard across the next rising edge.
  task automatic step(input logic iv, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] r, output logic rdy_o);
    logic exp_rdy;
    in_valid = iv;
    sel      = s;
    in_data  = d;
    set_ready(r);
    @(negedge clk);
    exp_rdy = (sbq[s].size() == 0) || r[s];
    rdy_o   = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(sbq[k].size() != 0));
      if (sbq[k].size() != 0) chk($sformatf("out_data%0d", k), 32'(od[k]), 32'(sbq[k][0]));
    end
    chk("xfer_count", 32'(xfer_count), 32'(m_count));
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (sbq[k].size() != 0 && r[k]) void'(sbq[k].pop_front());
    end
    if (iv && exp_rdy) begin
      sbq[s].push_back(d);
      m_count = m_count + 16'd1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic rdy;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 2'd0;
    in_data  = '0;
    set_ready(4'h0);
    clear_model();

    // Reset state: empty channels, zero count, ready for every sel.
    #3;
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'h0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single route: 0xA5 to channel 2.
    step(1'b1, 2'd2, 8'hA5, 4'h0, rdy);
    step(1'b0, 2'd0, 8'h00, 4'h0, rdy);
    chk("route_valid", 32'(ov), 32'h4);
    chk("route_data2", 32'(od2), 32'hA5);
    chk("route_count", 32'(xfer_count), 32'h1);
    step(1'b0, 2'd0, 8'h00, 4'h4, rdy);
    step(1'b0, 2'd0, 8'h00, 4'h0, rdy);

    // Table: backpressure, drain+load, fan-out, full-everywhere.
    vecs = '{
      '{1'b1, 2'd1, 8'h55, 4'h0, 1'b1},
      '{1'b1, 2'd1, 8'h66, 4'h0, 1'b0},
      '{1'b1, 2'd3, 8'h77, 4'h0, 1'b1},
      '{1'b0, 2'd1, 8'h99, 4'h0, 1'b0},
      '{1'b1, 2'd1, 8'h66, 4'h2, 1'b1},
      '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1},
      '{1'b1, 2'd0, 8'h10, 4'h0, 1'b1},
      '{1'b1, 2'd1, 8'h11, 4'h0, 1'b1},
      '{1'b1, 2'd2, 8'h12, 4'h0, 1'b1},
      '{1'b1, 2'd3, 8'h13, 4'h0, 1'b1},
      '{1'b1, 2'd2, 8'h14, 4'h0, 1'b0},
      '{1'b1, 2'd0, 8'h15, 4'h0, 1'b0},
      '{1'b0, 2'd0, 8'h00, 4'h0, 1'b0},
      '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1},
      '{1'b0, 2'd0, 8'h00, 4'h0, 1'b1}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].ordy, rdy);
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(vecs[i].exp_rdy));
    end

    // Streaming into channel 0 with its sink always ready.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'd0, 8'(i), 4'h1, rdy);
      chk("stream_ready", 32'(rdy), 32'h1);
    end
    step(1'b0, 2'd0, 8'h00, 4'h1, rdy);
    step(1'b0, 2'd0, 8'h00, 4'h1, rdy);

    // Reset mid-operation with channels 0 and 3 full.
    step(1'b1, 2'd0, 8'hE0, 4'h0, rdy);
    step(1'b1, 2'd3, 8'hE3, 4'h0, rdy);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov), 32'h0);
    chk("midrst_count", 32'(xfer_count), 32'h0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #0.5;
      chk("midrst_in_ready", 32'(in_ready), 32'h1);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Words discarded: sinks ready, nothing appears; first edge accepts.
    step(1'b1, 2'd1, 8'h3C, 4'hF, rdy);
    step(1'b0, 2'd0, 8'h00, 4'hF, rdy);
    chk("postrst_valid", 32'(ov), 32'h0);
    step(1'b0, 2'd0, 8'h00, 4'hF, rdy);

    // Counter wrap: 65535 acceptances, then one more.
    do_reset();
    in_valid = 1'b1;
    sel      = 2'd0;
    set_ready(4'h1);
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      @(posedge clk);
      #1;
    end
    sbq[0].push_back(8'hFE);
    m_count = 16'hFFFF;
    chk("wrap_pre", 32'(xfer_count), 32'hFFFF);
    step(1'b1, 2'd0, 8'h42, 4'h1, rdy);
    step(1'b0, 2'd0, 8'h00, 4'h1, rdy);
    chk("wrap_post", 32'(xfer_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux4_reg.md
DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits of the input and of every output channel.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: input word present.
REQ-005 SHALL have port in_ready, output, 1: input word is accepted this cycle when in_valid is also 1.
REQ-006 SHALL have port in_data, input, WIDTH: input word.
REQ-007 SHALL have port sel, input, 2: destination channel 0..3; sampled only while in_valid is 1.
REQ-008 SHALL have ports out_valid0..out_valid3, output, 1 each: channel k holds a word.
REQ-009 SHALL have ports out_ready0..out_ready3, input, 1 each: channel k sink takes its word this cycle.
REQ-010 SHALL have ports out_data0..out_data3, output, WIDTH each: channel k word.
REQ-011 SHALL have port xfer_count, output, 16: count of accepted input words.

Function
REQ-012 SHALL keep one holding register per channel, each with a full flag that drives out_validk directly.
REQ-013 SHALL assert in_ready combinationally when the channel addressed by sel is empty, or is full with its out_readyk = 1 in the same cycle.
REQ-014 SHALL NOT let in_ready depend on in_valid; in_ready for an unselected channel's state is irrelevant.
REQ-015 SHALL define input acceptance as in_valid & in_ready at a rising edge; the accepted word is stored in channel sel.
REQ-016 SHALL assert out_validk on the edge after acceptance, giving a fixed latency of 1 cycle from acceptance to out_validk.
REQ-017 SHALL define output transfer on channel k as out_validk & out_readyk at a rising edge; channel k then clears unless it is reloaded in the same edge.
REQ-018 SHALL handle simultaneous drain and accept on channel k by loading the new word and keeping out_validk = 1 with no bubble.
REQ-019 SHALL leave the other three channels' registers and flags unaffected by any acceptance.
REQ-020 SHALL drain all four channels independently and concurrently.
REQ-021 SHALL hold out_datak stable while out_validk = 1 and out_readyk = 0; data on an empty channel is don't-care.
REQ-022 SHALL ignore sel and in_data while in_valid = 0.
REQ-023 SHALL increment xfer_count by 1 on each acceptance and wrap from 0xFFFF to 0x0000.
REQ-024 SHALL NOT drop or duplicate words; per channel, delivery order equals acceptance order.

Reset
REQ-025 SHALL on rst_n = 0 immediately clear all four full flags, so that out_valid0..3 = 0, and set xfer_count = 0.
REQ-026 SHALL clear the holding data registers to 0 on reset.
REQ-027 SHALL discard buffered words when reset is asserted mid-operation, with no delivery after release.
REQ-028 SHALL make in_ready = 1 for every sel during and after reset, because all channels are empty.
REQ-029 SHALL resume normal acceptance on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover single route: WIDTH = 8, in_data = 0xA5, sel = 2, one-cycle valid -> next cycle out_valid2 = 1, out_data2 = 0xA5, other valids 0, xfer_count = 1.
REQ-031 SHALL cover backpressure: channel 1 full, out_ready1 = 0, sel = 1, in_valid = 1 -> in_ready = 0 and data held; in the same state sel = 3 -> in_ready = 1.
REQ-032 SHALL cover streaming: channel 0 with out_ready0 tied 1 and words 1,2,3,4 on consecutive cycles -> in_ready stays 1, out_data0 = 1,2,3,4 on consecutive cycles, no bubble.
REQ-033 SHALL cover fan-out: words 0x10..0x13 to sel 0..3 with all out_ready = 0 -> all four out_valid = 1 holding the matching words, and a fifth word to any sel sees in_ready = 0.
REQ-034 SHALL cover reset mid-operation: channels 0 and 3 full, rst_n pulsed low asynchronously between edges -> out_valid0..3 = 0 and xfer_count = 0 immediately, and neither word is ever delivered.
REQ-035 SHALL cover counter wrap: xfer_count preloaded by 65535 acceptances, then one more acceptance -> xfer_count = 0x0000.
